// File: rtl/dmem_arbiter.sv
// Two-master req/ack arbiter in front of the single-port data memory.
// Each transfer is latched at grant, waits WAIT_STATES cycles, then completes in one ACK cycle.
module dmem_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned ADDR_W     = 32;
  localparam logic [3:0]  WAIT_CNT   = 4'(WAIT_STATES);
  localparam logic        HAS_WAIT   = (WAIT_STATES > 0);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic                rr_pri, rr_pri_nxt;
  logic                we_q, we_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                winner;
  logic                legal;
  logic                ack_c;
  logic                err_c;
  logic [DATA_W-1:0]   rdata_c;

  // State and transfer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      rr_pri  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_pri  <= rr_pri_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Arbitration and sequencing; a locked master 1 keeps the grant under contention
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_pri_nxt = rr_pri;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    cnt_nxt    = cnt;
    winner     = m1_req;
    if (m0_req && m1_req) begin
      winner = (m1_lock && owner) ? 1'b1 : rr_pri;
    end
    unique case (state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          owner_nxt = winner;
          we_nxt    = winner ? m1_we    : m0_we;
          addr_nxt  = winner ? m1_addr  : m0_addr;
          wdata_nxt = winner ? m1_wdata : m0_wdata;
          cnt_nxt   = WAIT_CNT;
          state_nxt = HAS_WAIT ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        state_nxt  = S_IDLE;
        rr_pri_nxt = ~owner;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign legal = (addr_q[1:0] == 2'b00) && (addr_q < ADDR_LIMIT);

  // Memory strobes and completion; everything is forced low while reset is high
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack_c     = 1'b0;
    err_c     = 1'b0;
    rdata_c   = '0;
    if (state == S_ACK && !reset) begin
      ack_c = 1'b1;
      if (legal) begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = ~we_q;
        mem_write = we_q;
        rdata_c   = we_q ? '0 : mem_rdata;
      end else begin
        err_c = 1'b1;
      end
    end
  end

  assign m0_ack   = ack_c & ~owner;
  assign m0_err   = err_c & ~owner;
  assign m0_rdata = owner ? '0 : rdata_c;
  assign m1_ack   = ack_c & owner;
  assign m1_err   = err_c & owner;
  assign m1_rdata = owner ? rdata_c : '0;
  assign m0_stall = m0_req & ~m0_ack & ~reset;

endmodule
